// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction-byte prefetch queue with flush and in-flight discard
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'hFFFC
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [15:0]              flush_addr,
  output logic                     mem_rd,
  output logic [15:0]              mem_addr,
  input  logic [7:0]               mem_rdata,
  input  logic                     mem_ack,
  output logic                     byte_valid,
  input  logic                     byte_ready,
  output logic [7:0]               byte_data,
  output logic [15:0]              byte_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  state_t          state;
  logic [7:0]      data_q [DEPTH];
  logic [15:0]     pc_q   [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_next;
  logic [15:0]     fetch_pc;
  logic            push;
  logic            pop;

  // A completed live read is pushed; flush overrides both push and pop
  assign push = (state == REQ) && mem_ack && !flush;
  assign pop  = (count_q != '0) && byte_ready && !flush;

  // Occupancy after this edge's push/pop, used to decide back-to-back fetch
  always_comb begin
    count_next = count_q;
    if (push && !pop)
      count_next = count_q + 1'b1;
    else if (!push && pop)
      count_next = count_q - 1'b1;
  end

  // Fetch FSM, pointers and occupancy; mem_addr tracks fetch_pc except while
  // draining, where the discarded read's address must stay on the bus
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      mem_rd   <= 1'b0;
      mem_addr <= RESET_PC;
      fetch_pc <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      count_q  <= '0;
    end else if (flush) begin
      head     <= '0;
      tail     <= '0;
      count_q  <= '0;
      fetch_pc <= flush_addr;
      if (state != IDLE && !mem_ack) begin
        // a read is still outstanding; wait for it and drop its data
        state  <= DRAIN;
        mem_rd <= 1'b1;
      end else begin
        // nothing outstanding (or it completes now and is dropped)
        state    <= IDLE;
        mem_rd   <= 1'b0;
        mem_addr <= flush_addr;
      end
    end else begin
      if (push)
        tail <= tail + 1'b1;
      if (pop)
        head <= head + 1'b1;
      count_q <= count_next;
      case (state)
        IDLE: begin
          if (count_q < FULL) begin
            state    <= REQ;
            mem_rd   <= 1'b1;
            mem_addr <= fetch_pc;
          end
        end
        REQ: begin
          if (mem_ack) begin
            fetch_pc <= fetch_pc + 16'd1;
            mem_addr <= fetch_pc + 16'd1;
            if (count_next < FULL) begin
              state  <= REQ;
              mem_rd <= 1'b1;
            end else begin
              state  <= IDLE;
              mem_rd <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (mem_ack) begin
            state    <= IDLE;
            mem_rd   <= 1'b0;
            mem_addr <= fetch_pc;
          end
        end
        default: begin
          state  <= IDLE;
          mem_rd <= 1'b0;
        end
      endcase
    end
  end

  // Entry storage: written at the tail on every live push
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[tail] <= mem_rdata;
      pc_q[tail]   <= fetch_pc;
    end
  end

  assign byte_valid = (count_q != '0);
  assign byte_data  = byte_valid ? data_q[head] : 8'h00;
  assign byte_pc    = byte_valid ? pc_q[head]   : 16'h0000;
  assign count      = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue
module tb_fetch_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [15:0] flush_addr;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic        byte_valid;
  logic        byte_ready;
  logic [7:0]  byte_data;
  logic [15:0] byte_pc;
  logic [2:0]  count;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(16'hFFFC)) dut (
    .clk(clk), .reset(reset), .flush(flush), .flush_addr(flush_addr),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .byte_data(byte_data),
    .byte_pc(byte_pc), .count(count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: expected queue of PCs, next live fetch address, and
  // whether the outstanding read belongs to a flushed stream
  logic [15:0] mq[$];
  logic [15:0] m_pc;
  bit          stale;

  function automatic logic [7:0] fmem(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc  = 16'hFFFC;
    stale = 1'b0;
  endtask

  task automatic drive(input bit f, input logic [15:0] fa, input bit ack_en, input bit rdy);
    flush      = f;
    flush_addr = fa;
    mem_ack    = mem_rd & ack_en;
    mem_rdata  = fmem(mem_addr);
    byte_ready = rdy;
  endtask

  // advance one edge: update the model from the values the DUT samples, then check
  task automatic tick();
    bit pop;
    pop = (mq.size() > 0) && byte_ready && !flush;
    if (flush) begin
      mq.delete();
      m_pc  = flush_addr;
      stale = mem_rd && !mem_ack;
    end else begin
      if (pop) void'(mq.pop_front());
      if (mem_ack && mem_rd) begin
        if (stale) stale = 1'b0;
        else begin
          check("ack_addr", {16'h0, mem_addr}, {16'h0, m_pc});
          mq.push_back(m_pc);
          m_pc = m_pc + 16'd1;
        end
      end
    end
    @(posedge clk);
    #1;
    check("count", {29'h0, count}, mq.size());
    check("byte_valid", {31'h0, byte_valid}, {31'h0, mq.size() > 0});
    check("byte_pc", {16'h0, byte_pc}, mq.size() > 0 ? {16'h0, mq[0]} : 32'h0);
    check("byte_data", {24'h0, byte_data}, mq.size() > 0 ? {24'h0, fmem(mq[0])} : 32'h0);
    check("no_overfetch", {31'h0, (mem_rd && !stale && count == 3'd4)}, 32'h0);
  endtask

  logic [15:0] prev;
  logic [15:0] nxt;
  logic [15:0] old;

  initial begin
    reset = 1'b0; flush = 1'b0; flush_addr = 16'h0; mem_ack = 1'b0;
    mem_rdata = 8'h00; byte_ready = 1'b0;
    model_reset();
    #2;
    check("rst_mem_rd", {31'h0, mem_rd}, 0);
    check("rst_count", {29'h0, count}, 0);
    check("rst_valid", {31'h0, byte_valid}, 0);
    check("rst_data", {24'h0, byte_data}, 0);
    check("rst_pc", {16'h0, byte_pc}, 0);
    @(posedge clk); #1;
    reset = 1'b1;

    // 1: fill from reset vector, wrap of fetch PC
    drive(0, 16'h0, 0, 0); tick();
    check("t1_first_rd", {31'h0, mem_rd}, 1);
    check("t1_first_addr", {16'h0, mem_addr}, 32'hFFFC);
    for (int i = 0; i < 6; i++) begin drive(0, 16'h0, 1, 0); tick(); end
    check("t1_count", {29'h0, count}, 4);
    check("t1_mem_rd", {31'h0, mem_rd}, 0);
    check("t1_head", {16'h0, byte_pc}, 32'hFFFC);

    // 2: one pop from full queue, refetch at wrapped address
    drive(0, 16'h0, 1, 1); tick();
    check("t2_count", {29'h0, count}, 3);
    drive(0, 16'h0, 0, 0); tick();
    check("t2_rd", {31'h0, mem_rd}, 1);
    check("t2_addr", {16'h0, mem_addr}, 32'h0000);
    drive(0, 16'h0, 1, 0); tick();
    check("t2_refill", {29'h0, count}, 4);

    // 3: streaming, one byte per cycle with no gaps
    prev = 16'h0;
    for (int i = 0; i < 20; i++) begin
      drive(0, 16'h0, 1, 1); tick();
      if (i >= 4) begin
        nxt = prev + 16'd1;
        check("t3_cnt_le2", {31'h0, count <= 3'd2}, 1);
        check("t3_valid", {31'h0, byte_valid}, 1);
        check("t3_pc_inc", {16'h0, byte_pc}, {16'h0, nxt});
      end
      prev = byte_pc;
    end

    // 4: flush during pending REQ, ack arrives two cycles later
    drive(0, 16'h0, 0, 0); tick();
    old = m_pc;
    drive(1, 16'h1234, 0, 0); tick();
    check("t4_count", {29'h0, count}, 0);
    check("t4_drain_rd", {31'h0, mem_rd}, 1);
    check("t4_drain_addr", {16'h0, mem_addr}, {16'h0, old});
    drive(0, 16'h0, 0, 0); tick();
    check("t4_hold_rd", {31'h0, mem_rd}, 1);
    drive(0, 16'h0, 1, 0); tick();
    check("t4_dropped", {29'h0, count}, 0);
    check("t4_idle", {31'h0, mem_rd}, 0);
    drive(0, 16'h0, 0, 0); tick();
    check("t4_new_rd", {31'h0, mem_rd}, 1);
    check("t4_new_addr", {16'h0, mem_addr}, 32'h1234);
    drive(0, 16'h0, 1, 0); tick();
    check("t4_first_pc", {16'h0, byte_pc}, 32'h1234);

    // 5: flush, ack and pop on the same edge with two entries queued
    drive(0, 16'h0, 1, 0); tick();
    check("t5_pre_count", {29'h0, count}, 2);
    drive(1, 16'hABCD, 1, 1); tick();
    check("t5_count", {29'h0, count}, 0);
    check("t5_valid", {31'h0, byte_valid}, 0);
    check("t5_rd", {31'h0, mem_rd}, 0);
    drive(0, 16'h0, 0, 0); tick();
    check("t5_addr", {16'h0, mem_addr}, 32'hABCD);
    drive(0, 16'h0, 1, 0); tick();
    check("t5_pc", {16'h0, byte_pc}, 32'hABCD);
    check("t5_data", {24'h0, byte_data}, {24'h0, fmem(16'hABCD)});

    // 6: asynchronous reset in the middle of a request
    drive(0, 16'h0, 0, 0);
    #2;
    reset = 1'b0;
    #1;
    check("t6_rd", {31'h0, mem_rd}, 0);
    check("t6_count", {29'h0, count}, 0);
    check("t6_valid", {31'h0, byte_valid}, 0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    drive(0, 16'h0, 0, 0); tick();
    check("t6_restart_rd", {31'h0, mem_rd}, 1);
    check("t6_restart_addr", {16'h0, mem_addr}, 32'hFFFC);

    // randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      drive($urandom_range(0, 15) == 0, 16'($urandom), $urandom_range(0, 2) != 0,
            $urandom_range(0, 3) != 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
